// File: rtl/grid_cell_plotter.sv
// Column-request grid plotter: round-robin arbitration over per-column
// requests, paints one CELL_W x CELL_H rectangle per grant into VGA SRAM.
module grid_cell_plotter #(
   parameter int N_COLS   = 64,
   parameter int N_ROWS   = 64,
   parameter int CELL_W   = 10,
   parameter int CELL_H   = 7,
   parameter int X_ORIGIN = 0,
   parameter int Y_ORIGIN = 0,
   parameter int SCREEN_W = 640
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [N_COLS-1:0] col_select,
   input  logic [9:0]        row_select,
   input  logic [7:0]        pixel_color,
   output logic [N_COLS-1:0] return_sig,
   output logic [18:0]       vga_sram_address,
   output logic              vga_sram_write,
   output logic [7:0]        vga_sram_writedata,
   input  logic              vga_sram_waitrequest,
   output logic              busy
);

   localparam int CW  = (N_COLS > 1) ? $clog2(N_COLS) : 1;
   localparam int DXW = $clog2(CELL_W + 1);
   localparam int DYW = $clog2(CELL_H + 1);
   localparam logic [18:0] ROW_STEP = 19'(SCREEN_W - CELL_W + 1);

   typedef enum logic [2:0] {IDLE, GRANT, SETUP, DRAW, DONE} state_t;

   state_t            state;
   logic [CW-1:0]     rr_ptr;
   logic [CW-1:0]     cur_col;
   logic [CW-1:0]     grant_col;
   logic              grant_ok;
   logic [9:0]        row_q;
   logic [7:0]        color_q;
   logic [DXW-1:0]    dx;
   logic [DYW-1:0]    dy;
   logic [N_COLS-1:0] pending;
   logic [N_COLS-1:0] ret_next;
   logic [18:0]       px0;
   logic [18:0]       py0;
   logic [18:0]       start_addr;

   // A column whose ack is still high is not eligible again.
   assign pending = col_select & ~return_sig;

   always_comb begin
      int idx;
      idx       = 0;
      grant_ok  = 1'b0;
      grant_col = '0;
      for (int i = 0; i < N_COLS; i++) begin
         idx = int'(rr_ptr) + i;
         if (idx >= N_COLS) idx = idx - N_COLS;
         if (!grant_ok && pending[CW'(idx)]) begin
            grant_ok  = 1'b1;
            grant_col = CW'(idx);
         end
      end
   end

   assign px0        = 19'(X_ORIGIN) + 19'(cur_col) * 19'(CELL_W);
   assign py0        = 19'(Y_ORIGIN) + 19'(row_q) * 19'(CELL_H);
   assign start_addr = py0 * 19'(SCREEN_W) + px0;

   // Acks drop once the requester lets go; a set only comes from DONE.
   always_comb begin
      ret_next = return_sig & col_select;
      if (state == DONE && col_select[cur_col])
         ret_next[cur_col] = 1'b1;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state              <= IDLE;
         rr_ptr             <= '0;
         cur_col            <= '0;
         row_q              <= '0;
         color_q            <= '0;
         dx                 <= '0;
         dy                 <= '0;
         return_sig         <= '0;
         vga_sram_address   <= '0;
         vga_sram_write     <= 1'b0;
         vga_sram_writedata <= '0;
         busy               <= 1'b0;
      end else begin
         return_sig <= ret_next;
         unique case (state)
            IDLE: begin
               if (|pending) begin
                  state <= GRANT;
                  busy  <= 1'b1;
               end
            end
            GRANT: begin
               if (grant_ok) begin
                  cur_col <= grant_col;
                  row_q   <= row_select;
                  color_q <= pixel_color;
                  rr_ptr  <= (grant_col == CW'(N_COLS - 1)) ?
                             '0 : grant_col + CW'(1);
                  state   <= SETUP;
               end else begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            SETUP: begin
               dx <= '0;
               dy <= '0;
               if (int'(row_q) >= N_ROWS) begin
                  state <= DONE;
               end else begin
                  vga_sram_write     <= 1'b1;
                  vga_sram_address   <= start_addr;
                  vga_sram_writedata <= color_q;
                  state              <= DRAW;
               end
            end
            DRAW: begin
               if (!vga_sram_waitrequest) begin
                  if (dx == DXW'(CELL_W - 1)) begin
                     dx <= '0;
                     if (dy == DYW'(CELL_H - 1)) begin
                        vga_sram_write <= 1'b0;
                        state          <= DONE;
                     end else begin
                        dy               <= dy + DYW'(1);
                        vga_sram_address <= vga_sram_address + ROW_STEP;
                     end
                  end else begin
                     dx               <= dx + DXW'(1);
                     vga_sram_address <= vga_sram_address + 19'd1;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/grid_cell_plotter.md
Name: grid_cell_plotter

Overview:
- Consumer of the column-request plotting handshake (col_select / row_select / pixel_color / return_sig) driven by the heat-map reader/plotter.
- Arbitrates among per-column requests and paints one CELL_W x CELL_H pixel rectangle per request into the 8-bit VGA pixel SRAM.
- Acknowledges each request on the matching return_sig bit using a 4-phase handshake.

Parameters:
N_COLS, 64, number of grid columns; width of col_select and return_sig
N_ROWS, 64, number of grid rows; valid row_select range 0..N_ROWS-1
CELL_W, 10, pixel width of one grid cell
CELL_H, 7, pixel height of one grid cell
X_ORIGIN, 0, screen x of cell (0,0) top-left pixel
Y_ORIGIN, 0, screen y of cell (0,0) top-left pixel
SCREEN_W, 640, pixels per VGA line; address stride

Ports:
clock  input  1  system clock (CLOCK_50 domain)
reset  input  1  synchronous, active-high
col_select  input  N_COLS  per-column request; held high until acknowledged
row_select  input  10  grid row of the request; shared by all columns
pixel_color  input  8  colour of the request; shared
return_sig  output  N_COLS  per-column acknowledge
vga_sram_address  output  19  pixel address = y*SCREEN_W + x
vga_sram_write  output  1  write strobe
vga_sram_writedata  output  8  pixel colour
vga_sram_waitrequest  input  1  while high, the current write is not accepted
busy  output  1  high in every state except IDLE

Behaviour:
- Reset, sync active-high, clock: return_sig=0, vga_sram_write=0, vga_sram_address=0, vga_sram_writedata=0, busy=0, rr_ptr=0, state=IDLE. Reset during DRAW drops the write strobe on the next edge; no ack is issued.
- pending[c] = col_select[c] & ~return_sig[c].
- Ack bookkeeping runs independently of the FSM every cycle: if return_sig[c]=1 and col_select[c]=0, clear return_sig[c] on the next edge.
- A column is never re-served while its return_sig bit is high. This prevents a stale ack from being seen on the next request.
- FSM states: IDLE, GRANT, SETUP, DRAW, DONE.
- IDLE: if any pending bit is set, go to GRANT; otherwise stay.
- GRANT: choose c = first pending index at or after rr_ptr, wrapping modulo N_COLS (round-robin).
  - Latch c, row_select and pixel_color.
  - Set rr_ptr = (c+1) mod N_COLS.
  - If pending has cleared by this cycle, return to IDLE.
- SETUP: compute px0 = X_ORIGIN + c*CELL_W and py0 = Y_ORIGIN + row*CELL_H, then the start address py0*SCREEN_W + px0. Set dx=dy=0.
  - If the latched row >= N_ROWS, skip to DONE with no writes.
- DRAW: drive vga_sram_write=1, address=(py0+dy)*SCREEN_W+(px0+dx), writedata=latched colour.
  - Advance only on a cycle with write=1 and waitrequest=0.
  - Raster order: dx increments first; at dx=CELL_W-1, dx wraps to 0 and dy increments.
  - After the write at dx=CELL_W-1, dy=CELL_H-1 is accepted, deassert write and go to DONE.
  - Address and data stay stable while waitrequest is high.
- DONE: if col_select[c] is still 1, set return_sig[c]=1. If the request was withdrawn mid-draw, the rectangle is still completed but no ack is issued. Return to IDLE.
- Latency with waitrequest=0:
  - GRANT occurs 1 cycle after the request is seen in IDLE.
  - The first write is asserted 2 cycles after GRANT.
  - CELL_W*CELL_H write cycles follow.
  - return_sig rises 1 cycle after the last accepted write (3+70+1 cycles with defaults).
- Arithmetic: unsigned; addresses are 19 bits (max 307199 for 640x480). Parameters must satisfy Y_ORIGIN+N_ROWS*CELL_H <= 480 and X_ORIGIN+N_COLS*CELL_W <= SCREEN_W; no clipping is performed.
- Simultaneous events: requests arriving during DRAW wait. The ack-clear and grant of different columns may occur in the same cycle.

Test Plan:
- Single request: col_select[3]=1, row=2, colour=0xFF, waitrequest=0 -> exactly 70 writes, addresses 14*640+30..39 through 20*640+30..39 in raster order, data 0xFF; return_sig[3] rises 74 cycles after the request; drop col_select[3] -> return_sig[3]=0 next cycle.
- Round-robin: col_select bits 0, 5, 63 raised together -> service order 0, 5, 63. Then re-raise 0 and 5 with rr_ptr=0 (wrapped from 63) -> order 0, 5.
- Backpressure: waitrequest toggling 1/0 every cycle during DRAW -> still 70 accepted writes; address and data held stable through every stall cycle.
- Invalid row: row_select=64 -> no vga_sram_write pulses; return_sig bit set within 4 cycles.
- Stale-ack guard and withdrawal: hold col_select[7] high after its ack -> no second draw. Withdraw col_select[9] during DRAW -> the rectangle completes and return_sig[9] stays 0.
- Reset mid-DRAW: assert reset at write 20 -> next cycle write=0, return_sig=0, busy=0, state IDLE; a fresh request is then served normally.
